// File: rtl/mem_bus_pkg.sv
// Types and defaults shared by the memory-bus initiators and the memory model.
// The CSUM state exists only when DUMP_CHECKSUM_EN is defined.
package mem_bus_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;
  localparam int WORD_BYTES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND,
`ifdef DUMP_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE
  } dump_state_t;

endpackage

// File: rtl/mem_dump_reader.sv
// Reads word_count little-endian words from base_addr over the shared bus and streams them out.
// Define DUMP_CHECKSUM_EN to append a 16-bit modular checksum beat carrying out_last.
module mem_dump_reader
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  output logic              busy,
  output logic              done,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] addr,
  output logic              en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  dump_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [15:0]       remaining_reg, remaining_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              valid_reg, valid_next;
  logic              last_reg, last_next;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_reg, csum_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      last_reg      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_reg      <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      last_reg      <= last_next;
`ifdef DUMP_CHECKSUM_EN
      csum_reg      <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    data_next      = data_reg;
    valid_next     = valid_reg;
    last_next      = last_reg;
`ifdef DUMP_CHECKSUM_EN
    csum_next      = csum_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          addr_next      = base_addr;
          remaining_next = word_count;
`ifdef DUMP_CHECKSUM_EN
          csum_next      = '0;
`endif
          if (word_count != 16'd0) begin
            state_next = ST_READ;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            // Empty dump still emits the (zero) checksum beat.
            data_next  = '0;
            valid_next = 1'b1;
            last_next  = 1'b1;
            state_next = ST_CSUM;
`else
            state_next = ST_DONE;
`endif
          end
        end
      end
      ST_READ: begin
        if (bus_gnt) begin
          data_next      = rd_data;
          valid_next     = 1'b1;
          remaining_next = remaining_reg - 16'd1;
`ifdef DUMP_CHECKSUM_EN
          csum_next      = csum_reg + rd_data;
          last_next      = 1'b0;
`else
          last_next      = (remaining_reg == 16'd1);
`endif
          state_next     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          if (remaining_reg != 16'd0) begin
            addr_next  = addr_reg + ADDR_W'(WORD_BYTES);
            state_next = ST_READ;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            // csum_reg already includes the word just delivered.
            data_next  = csum_reg;
            valid_next = 1'b1;
            last_next  = 1'b1;
            state_next = ST_CSUM;
`else
            state_next = ST_DONE;
`endif
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (out_ready) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          state_next = ST_DONE;
        end
      end
`endif
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign bus_req   = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign addr      = addr_reg;
  assign en        = 1'b0;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_last  = last_reg;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: table of directed dumps plus random dumps checked against a memory-walk model.
// Expectations follow DUMP_CHECKSUM_EN the same way the design does.
module tb_mem_dump_reader;
  import mem_bus_pkg::*;

  localparam int AW = MEM_ADDR_W;
  localparam int DW = MEM_DATA_W;
`ifdef DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, busy, done, bus_req, bus_gnt, en;
  logic          out_valid, out_ready, out_last;
  logic [AW-1:0] base_addr, addr, addr_hi;
  logic [15:0]   word_count;
  logic [DW-1:0] rd_data, out_data;
  logic [7:0]    mem [0:65535];
  int            n_vec = 0;
  int            n_err = 0;

  typedef struct {
    int base;
    int count;
    int ready_hold;
    int gnt_at;
    int gnt_len;
    int rnd;
    int poke;
    int exp_beats;
    int exp_final;
  } tcase_t;

  mem_dump_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .bus_req(bus_req), .bus_gnt(bus_gnt), .addr(addr), .en(en),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  assign addr_hi = addr + 16'd1;
  assign rd_data = {mem[addr_hi], mem[addr]};

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_bus_req"}, bus_req, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_en"}, en, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
  endtask

  task automatic run_dump(input int idx, input tcase_t tc);
    int exp_d[$];
    int exp_a[$];
    logic [15:0] a, a1, sum;
    int beats = 0, caps = 0, hold = 0, reads = 0, cyc = 0, last_data = -1;
    int stall = tc.gnt_len;
    bit prev_read = 0, prev_nocap = 0, waiting = 0, expect_done = 0, got_done = 0;
    logic [15:0] prev_data = '0;

    // Reference: walk memory word by word, addresses wrapping at 64 KiB.
    sum = '0;
    for (int i = 0; i < tc.count; i++) begin
      a  = 16'(tc.base + 2 * i);
      a1 = a + 16'd1;
      exp_a.push_back(int'(a));
      exp_d.push_back(int'({mem[a1], mem[a]}));
      sum = sum + {mem[a1], mem[a]};
    end
    if (CS == 1) exp_d.push_back(int'(sum));

    @(negedge clk);
    base_addr  = 16'(tc.base);
    word_count = 16'(tc.count);
    start      = 1'b1;
    bus_gnt    = 1'b1;
    out_ready  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (exp_d.size() == 0) expect_done = 1;

    while (!got_done && cyc < 3000) begin
      cyc++;
      if (tc.poke != 0 && cyc == 3) begin
        start      = 1'b1;
        base_addr  = 16'h0100;
        word_count = 16'd7;
      end else begin
        start = 1'b0;
      end
      if (expect_done) begin
        check("done_pulse", done, 1);
        got_done = 1;
      end else begin
        check("done_low", done, 0);
        if (prev_nocap) check("no_capture_without_gnt", out_valid, 0);
        prev_nocap = 0;
        if (bus_req && !out_valid) begin
          if (!prev_read) reads++;
          if (tc.rnd != 0) bus_gnt = ($urandom_range(0, 2) != 0);
          else begin
            bus_gnt = !(reads == tc.gnt_at && stall > 0);
            if (!bus_gnt) stall--;
          end
          if (bus_gnt) begin
            check("read_addr", addr, (caps < exp_a.size()) ? exp_a[caps] : -1);
            caps++;
          end else begin
            prev_nocap = 1;
          end
          prev_read = 1;
        end else begin
          prev_read = 0;
          bus_gnt = (tc.rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (out_valid) begin
          if (waiting) check("stable_data", out_data, prev_data);
          if (tc.rnd != 0) out_ready = ($urandom_range(0, 2) == 0);
          else out_ready = (hold >= tc.ready_hold);
          hold++;
          if (out_ready) begin
            check("beat_data", out_data, (beats < exp_d.size()) ? exp_d[beats] : -1);
            check("beat_last", out_last, (beats == exp_d.size() - 1) ? 1 : 0);
            last_data = out_data;
            beats++;
            hold = 0;
            waiting = 0;
            if (beats == exp_d.size()) expect_done = 1;
          end else begin
            waiting = 1;
            prev_data = out_data;
          end
        end else begin
          if (waiting) check("valid_held", out_valid, 1);
          waiting = 0;
          hold = 0;
          out_ready = (tc.rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", got_done, 1);
    check("beat_count_model", beats, exp_d.size());
    check("beat_count_table", beats, tc.exp_beats);
    check("capture_count", caps, tc.count);
    if (tc.exp_final >= 0) check("final_beat", last_data, tc.exp_final);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    out_ready = 1'b0;
    bus_gnt   = 1'b0;
    $display("dump %0d: base=0x%04h count=%0d beats=%0d cycles=%0d", idx, tc.base, tc.count, beats, cyc);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tcase_t tbl[7];
    tcase_t rc;
    int beats, cyc;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 10; i++) begin
      mem[1000 + 2 * i]     = 8'(9 - i);
      mem[1000 + 2 * i + 1] = 8'h00;
    end
    mem[16'hFFFE] = 8'hFE;
    mem[16'hFFFF] = 8'hFF;
    mem[0] = 8'h00;
    mem[1] = 8'h00;

    tbl[0] = '{1000, 10, 0, 0, 0, 0, 0, 10 + CS, (CS == 1) ? 16'h002D : 0};
    tbl[1] = '{1000, 10, 3, 0, 0, 0, 0, 10 + CS, (CS == 1) ? 16'h002D : 0};
    tbl[2] = '{1000, 10, 0, 4, 5, 0, 0, 10 + CS, (CS == 1) ? 16'h002D : 0};
    tbl[3] = '{16'hFFFE, 2, 0, 0, 0, 0, 0, 2 + CS, (CS == 1) ? 16'hFFFE : 0};
    tbl[4] = '{1000, 0, 0, 0, 0, 0, 0, CS, (CS == 1) ? 0 : -1};
    tbl[5] = '{1000, 3, 1, 0, 0, 0, 1, 3 + CS, (CS == 1) ? 24 : 7};
    tbl[6] = '{1001, 4, 2, 2, 3, 0, 0, 4 + CS, -1};

    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    bus_gnt = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_dump(i, tbl[i]);

    for (int i = 0; i < 12; i++) begin
      rc.base       = int'($urandom_range(0, 65535));
      rc.count      = int'($urandom_range(0, 6));
      rc.ready_hold = 0;
      rc.gnt_at     = 0;
      rc.gnt_len    = 0;
      rc.rnd        = 1;
      rc.poke       = 0;
      rc.exp_beats  = rc.count + CS;
      rc.exp_final  = -1;
      run_dump(7 + i, rc);
    end

    // Reset while the third word waits unacknowledged in SEND.
    @(negedge clk);
    base_addr = 16'd1000; word_count = 16'd10; start = 1'b1; bus_gnt = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    beats = 0;
    cyc = 0;
    while (cyc < 200) begin
      if (out_valid && beats == 2) break;
      if (out_valid) beats++;
      @(negedge clk);
      cyc++;
    end
    check("reached_third_send", beats, 2);
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    bus_gnt = 1'b0;
    $display("dump reset: aborted after %0d beats", beats);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
